// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered, parametrised binary-to-one-hot decoder.
//
// Three run-time modes:
//   LEVEL (00) - accepted sel is latched and 1<<sel is held on out.
//   PULSE (01) - accepted sel produces 1<<sel for exactly one cycle.
//   SCAN  (10) - self-timed walking one; each index is held DWELL cycles.
//   11         - reserved: out = 0, internal state holds.
//
// Handshake: sel is accepted on a rising edge when
// enable & sel_valid & (mode is LEVEL or PULSE). There is no ready;
// the decoder always takes an offered select in those modes.
//
// Parameters:
//   SEL_W  select width, 1..6
//   OUT_W  number of outputs, 2 <= OUT_W <= 2**SEL_W
//   DWELL  SCAN cycles per index, >= 1 (>= 2 with DEC_BBM_EN)
//
// Optional feature (macro DEC_BBM_EN): break-before-make. In LEVEL a
// direct A -> B change of out inserts one all-zero cycle. In SCAN the
// first dwell cycle of each new index is forced to zero. PULSE is unaffected.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   enable     global output enable (low: out = 0, state frozen)
//   mode       operating mode, see above
//   sel        requested output index
//   sel_valid  sel qualifier
//   out        registered one-hot or all-zero output
//   cur_sel    index of the active output, 0 when out == 0
//   active     registered |out
//   sel_err    one-cycle pulse: an out-of-range sel was accepted
module decoder_nx_seq #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             sel_valid,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] cur_sel,
  output logic             active,
  output logic             sel_err
);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

`ifdef DEC_BBM_EN
  localparam bit BBM = 1'b1;
`else
  localparam bit BBM = 1'b0;
`endif

  // Internal state
  logic [SEL_W-1:0] lat_sel;    // LEVEL latched select
  logic             lat_vld;    // 0 means latched select is "none"
  logic [SEL_W-1:0] scan_idx;
  logic [CNT_W-1:0] dwell_cnt;  // cycles the current index has been driven
  logic             scan_run;   // last enabled edge was in SCAN mode

  // Next-state values
  logic [SEL_W-1:0] nxt_lat_sel;
  logic             nxt_lat_vld;
  logic [SEL_W-1:0] nxt_idx;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_run;
  logic             nxt_err;
  logic             tgt_vld;
  logic [SEL_W-1:0] tgt_sel;
  logic [SEL_W-1:0] wrap_idx;

  logic  accept;
  logic  in_range;
  mode_e mode_q;

  assign mode_q   = mode_e'(mode);
  assign accept   = enable & sel_valid &
                    ((mode_q == MODE_LEVEL) | (mode_q == MODE_PULSE));
  assign in_range = (int'(sel) < OUT_W);
  assign wrap_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + SEL_W'(1);

  always_comb begin
    nxt_lat_sel = lat_sel;
    nxt_lat_vld = lat_vld;
    nxt_idx     = scan_idx;
    nxt_cnt     = dwell_cnt;
    nxt_run     = scan_run;
    nxt_err     = 1'b0;
    tgt_vld     = 1'b0;
    tgt_sel     = '0;

    // With enable low everything holds and out goes to zero.
    if (enable) begin
      nxt_run = (mode_q == MODE_SCAN);
      case (mode_q)
        MODE_LEVEL: begin
          if (accept) begin
            if (in_range) begin
              nxt_lat_sel = sel;
              nxt_lat_vld = 1'b1;
            end else begin
              nxt_lat_sel = '0;
              nxt_lat_vld = 1'b0;
              nxt_err     = 1'b1;
            end
          end
          tgt_vld = nxt_lat_vld;
          tgt_sel = nxt_lat_sel;
          // A -> B goes through one zero cycle; the latch still holds B,
          // so B appears on the following edge.
          if (BBM && tgt_vld && active && (cur_sel != tgt_sel)) begin
            tgt_vld = 1'b0;
          end
        end
        MODE_PULSE: begin
          if (accept) begin
            if (in_range) begin
              tgt_vld = 1'b1;
              tgt_sel = sel;
            end else begin
              nxt_err = 1'b1;
            end
          end
        end
        MODE_SCAN: begin
          if (!scan_run) begin
            // Fresh entry: start at index 0 with no gap.
            nxt_idx = '0;
            nxt_cnt = CNT_W'(1);
            tgt_vld = 1'b1;
            tgt_sel = '0;
          end else if (dwell_cnt >= DWELL_C) begin
            // The break cycle is the first dwell cycle of the new index,
            // so the scan period does not stretch.
            nxt_idx = wrap_idx;
            nxt_cnt = CNT_W'(1);
            tgt_vld = !BBM;
            tgt_sel = wrap_idx;
          end else begin
            nxt_cnt = dwell_cnt + CNT_W'(1);
            tgt_vld = 1'b1;
            tgt_sel = scan_idx;
          end
        end
        default: begin
          // Reserved: out = 0, state holds.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      cur_sel   <= '0;
      active    <= 1'b0;
      sel_err   <= 1'b0;
      lat_sel   <= '0;
      lat_vld   <= 1'b0;
      scan_idx  <= '0;
      dwell_cnt <= '0;
      scan_run  <= 1'b0;
    end else begin
      out       <= tgt_vld ? (OUT_W'(1) << tgt_sel) : '0;
      cur_sel   <= tgt_vld ? tgt_sel : '0;
      active    <= tgt_vld;
      sel_err   <= nxt_err;
      lat_sel   <= nxt_lat_sel;
      lat_vld   <= nxt_lat_vld;
      scan_idx  <= nxt_idx;
      dwell_cnt <= nxt_cnt;
      scan_run  <= nxt_run;
    end
  end

endmodule

// File: doc/decoder_nx_seq.md
Name: decoder_nx_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. It is the next generation of the combinational 3-to-8 decoder.
- Adds a configurable output count and three run-time modes: LEVEL (latched select), PULSE (single-cycle strobe) and SCAN (self-timed walking one).
- Drives display-digit, chip-select and row-scan lines.
- Outputs are always registered.

Parameters:
SEL_W, 3, select width in bits; must be 1..6.
OUT_W, 8, number of one-hot outputs; must satisfy 2 <= OUT_W <= 2**SEL_W.
DWELL, 4, SCAN mode: cycles each output stays active; must be >= 1 (>= 2 when DEC_BBM_EN is defined).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous reset, active low.
enable  input  1  global output enable.
mode  input  2  00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved.
sel  input  SEL_W  requested output index.
sel_valid  input  1  sel qualifier; sampled at the rising edge.
out  output  OUT_W  registered one-hot (or all-zero) output.
cur_sel  output  SEL_W  index of the currently active output; 0 when out == 0.
active  output  1  registered, equals |out.
sel_err  output  1  one-cycle pulse: an out-of-range sel was accepted.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is synchronous and active low: sampled only on the rising edge of clk.
- Reset: while rst_n == 0 at the edge:
  - out, cur_sel, active and sel_err all become 0.
  - Latched select becomes 0; scan index becomes 0; dwell counter becomes 0.
  - Reset mid-scan or mid-pulse aborts the operation immediately; no residual pulse.
- Acceptance: sel is accepted when enable & sel_valid & (mode is 00 or 01).
  - sel >= OUT_W: sel_err pulses high in cycle t+1.
    - LEVEL: out becomes 0 and the latched select is cleared to "none".
    - PULSE: no pulse is issued.
- LEVEL (00): accepted sel at edge t drives out = 1<<sel from cycle t+1 and holds it until the next accepted sel. Latency is 1.
- PULSE (01): accepted sel at edge t drives out = 1<<sel for exactly cycle t+1, then 0.
  - Back-to-back valids produce back-to-back pulses. Pulses on the same index merge into a continuous high.
- SCAN (10): sel and sel_valid are ignored.
  - Scan index starts at 0 on the first cycle in SCAN mode (entry from any other mode, or from reset).
  - Each index is held for DWELL cycles, then increments. OUT_W-1 wraps to 0. Period is OUT_W*DWELL cycles.
  - out = 1<<index from the cycle after entry.
- Reserved (11): out = 0; internal state holds.
- enable low: out is forced to 0 on the next cycle. The latched select, scan index and dwell counter are frozen.
  - On re-enable, LEVEL restores the latched output at t+1.
  - On re-enable, SCAN resumes the same index with the remaining dwell.
  - A PULSE pending at the disable edge is dropped.
- Mode change: takes effect on the next edge. Leaving LEVEL keeps the latched select; returning to LEVEL re-outputs it.
- Invariant: out is always 0 or exactly one-hot; bits >= OUT_W are never set. cur_sel and active track out in the same cycle.

Optional Feature:
- Macro: DEC_BBM_EN (break-before-make).
- Defined:
  - LEVEL: a transition of out from one-hot A to a different one-hot B inserts exactly one all-zero cycle, so B appears at t+2.
  - SCAN: the zero cycle replaces the first dwell cycle of the new index, so the period is unchanged.
  - Transitions A to 0 and 0 to B are not delayed.
  - PULSE mode is unaffected.
- Undefined: no gap; A switches directly to B.

Test Plan:
- Reset/LEVEL: rst_n=0 for 2 cycles, then enable=1, mode=00, sel=5, sel_valid=1 at edge t -> out=8'h20, cur_sel=5, active=1 from t+1; it holds with sel_valid=0 and returns to 0 after rst_n=0.
- PULSE: mode=01, sel=2 at t, then sel=7 at t+1 -> out=8'h04 in t+1, 8'h80 in t+2, 8'h00 in t+3.
- SCAN wrap (OUT_W=8, DWELL=4): enter mode=10 -> out walks 8'h01 (4 cycles), 8'h02 (4 cycles) ... 8'h80 (4 cycles), then back to 8'h01 at cycle 33. An enable low for 3 cycles mid-dwell -> out=0 for those cycles, then the same index resumes with its remaining dwell.
- Range error (OUT_W=6, SEL_W=3): LEVEL with sel=6 accepted while out=6'h04 -> sel_err high for 1 cycle, out=0, cur_sel=0. A later enable toggle restores nothing.
- Break-before-make (DEC_BBM_EN defined): LEVEL sel=1 then sel=3 -> out 8'h02, 8'h00 (1 cycle), 8'h08. Without the macro -> 8'h02 then 8'h08 directly.
- Mid-operation reset: SCAN at index 4, rst_n=0 for 1 edge -> all outputs 0. On release with mode still 10, out=8'h01 the following cycle.
